// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// one-entry holding register presented on a valid/ready port.
package uart_pkg;
  typedef enum int unsigned {
    BR_9600   = 9600,
    BR_19200  = 19200,
    BR_38400  = 38400,
    BR_57600  = 57600,
    BR_115200 = 115200
  } uart_baud_rate_t;
endpackage

module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned     CLK_FREQ_HZ = 100_000_000,
  parameter uart_baud_rate_t BAUD_RATE   = BR_115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / int'(BAUD_RATE);
  localparam int unsigned CLKS_HALF    = CLKS_PER_BIT / 2;
  localparam int          CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_HALF - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_rx: CLKS_PER_BIT must be >= 4");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            rx_s;
  logic            byte_done;
  logic            pop;

  assign rx_s = sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= rx;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Each sample point clears the clock counter, so it never wraps inside a state.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_done   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_cnt_q] = rx_s;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            byte_done = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        clk_cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid/ready: a byte transfers on every cycle where rx_valid && rx_ready.
  // A completing byte may replace a byte popped in the same cycle; otherwise
  // it is dropped and overrun is flagged (set wins over the handshake clear).
  always_comb begin
    pop        = rx_valid_q && rx_ready;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    overrun_d  = overrun_q;
    if (pop) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
    if (byte_done) begin
      if (!rx_valid_q || pop) begin
        rx_valid_d = 1'b1;
        rx_data_d  = shift_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; a negedge monitor records
// handshakes and frame errors, the main sequence checks them against exp_q.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CLK_HZ = 1_843_200;
  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         hs_rd = 0;
  int         fe_cnt = 0;
  int         valid_cnt = 0;
  int         fe_base;
  int         valid_base;

  uart_rx #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BR_115200)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 unit after posedge, so negedge sees stable in/out values.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (rx_valid) valid_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_sb(input string tag);
    logic [7:0] e;
    check({tag, "_count"}, got_q.size() - hs_rd, exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (hs_rd < got_q.size()) begin
        check({tag, "_byte"}, got_q[hs_rd], e);
        hs_rd++;
      end
    end
    hs_rd = got_q.size();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    tick(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
  endtask

  initial begin
    rst_n    = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    tick(3);
    check("reset_valid", rx_valid, 1'b0);
    check("reset_data", rx_data, 8'h00);
    check("reset_ferr", frame_err, 1'b0);
    check("reset_ovr", overrun, 1'b0);
    rst_n = 1'b1;
    idle(2 * CPB);

    // Single byte, consumer always ready: one-cycle valid pulse.
    rx_ready   = 1'b1;
    fe_base    = fe_cnt;
    valid_base = valid_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(8);
    check_sb("t1");
    check("t1_valid_cycles", valid_cnt - valid_base, 1);
    check("t1_ferr", fe_cnt - fe_base, 0);
    check("t1_ovr", overrun, 1'b0);

    // Back-to-back frames with no idle gap.
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    idle(8);
    check_sb("t2");

    // Consumer stalled: second byte is dropped and overrun is raised.
    rx_ready = 1'b0;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    idle(8);
    check("t3_valid_held", rx_valid, 1'b1);
    check("t3_data_held", rx_data, 8'h12);
    check("t3_ovr_set", overrun, 1'b1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("t3_valid_clr", rx_valid, 1'b0);
    check("t3_ovr_clr", overrun, 1'b0);
    exp_q.push_back(8'h12);
    check_sb("t3");

    // Framing error followed by a break: one pulse, no restart while low.
    rx_ready = 1'b1;
    fe_base  = fe_cnt;
    send_frame(8'h3C, 1'b0);
    tick(20 * CPB);
    check("t4_ferr_pulses", fe_cnt - fe_base, 1);
    check("t4_no_valid", rx_valid, 1'b0);
    check_sb("t4_none");
    idle(2 * CPB);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle(8);
    check_sb("t4");
    check("t4_ferr_after", fe_cnt - fe_base, 1);

    // Short low glitch is rejected at the start-bit midpoint.
    fe_base = fe_cnt;
    rx = 1'b0;
    tick(5);
    idle(3 * CPB);
    check("t5_no_valid", rx_valid, 1'b0);
    check("t5_no_ferr", fe_cnt - fe_base, 0);
    check_sb("t5_none");
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    idle(8);
    check_sb("t5");

    // Build pending state, then reset during data bit 4 of a frame.
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    send_frame(8'h66, 1'b1);
    idle(8);
    check("t6_pre_valid", rx_valid, 1'b1);
    check("t6_pre_data", rx_data, 8'h5A);
    check("t6_pre_ovr", overrun, 1'b1);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      tick(CPB);
    end
    rx = 1'b1;
    tick(CPB / 2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", rx_valid, 1'b0);
    check("t6_rst_data", rx_data, 8'h00);
    check("t6_rst_ovr", overrun, 1'b0);
    check("t6_rst_ferr", frame_err, 1'b0);
    tick(3);
    rx    = 1'b1;
    rst_n = 1'b1;
    idle(2 * CPB);
    rx_ready = 1'b1;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    idle(8);
    check_sb("t6");
    check("t6_ovr_final", overrun, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
